// File: rtl/pw_capture_seq.sv
// Pulse-width capture sequencer: arm, wait for match, optional delay, gated capture window.
// Optional ARMED timeout is built only when PW_SEQ_TIMEOUT_EN is defined.
module pw_capture_seq #(
  parameter int pCAPTURE_LEN_WIDTH = 16,
  parameter int pDELAY_WIDTH       = 16,
  parameter int pTIMEOUT_WIDTH     = 24
) (
  input  logic                          fe_clk,
  input  logic                          reset_i,
  input  logic                          I_arm,
  input  logic                          I_disarm,
  input  logic                          I_match,
  input  logic                          I_fe_wr,
  input  logic                          I_fifo_full,
  input  logic [pCAPTURE_LEN_WIDTH-1:0] I_capture_len,
  input  logic [pDELAY_WIDTH-1:0]       I_capture_delay,
  input  logic [pTIMEOUT_WIDTH-1:0]     I_timeout,
  output logic                          O_armed,
  output logic                          O_capture_enable,
  output logic                          O_done,
  output logic                          O_overflow,
  output logic                          O_timeout,
  output logic [2:0]                    O_state,
  output logic [pCAPTURE_LEN_WIDTH-1:0] O_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [pCAPTURE_LEN_WIDTH-1:0] CNT_ONE = {{(pCAPTURE_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pDELAY_WIDTH-1:0]       DLY_ONE = {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};

  state_t                        state_q, state_d;
  logic [pCAPTURE_LEN_WIDTH-1:0] len_q, len_d;
  logic [pDELAY_WIDTH-1:0]       dly_q, dly_d;
  logic [pDELAY_WIDTH-1:0]       dcnt_q, dcnt_d;
  logic [pCAPTURE_LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [pCAPTURE_LEN_WIDTH-1:0] cnt_inc;
  logic                          ovf_q, ovf_d;
  logic                          tmo_q, tmo_d;
  logic                          done_q, done_d;

`ifdef PW_SEQ_TIMEOUT_EN
  localparam logic [pTIMEOUT_WIDTH-1:0] TO_ONE = {{(pTIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  logic [pTIMEOUT_WIDTH-1:0] to_q, to_d;
  logic [pTIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^I_timeout;
`endif

  // Count saturates at all-ones rather than wrapping.
  assign cnt_inc = (cnt_q == {pCAPTURE_LEN_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dly_d   = dly_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
`ifdef PW_SEQ_TIMEOUT_EN
    to_d    = to_q;
    tcnt_d  = tcnt_q;
`endif
    if (I_disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_arm) begin
            state_d = ST_ARMED;
            len_d   = I_capture_len;
            dly_d   = I_capture_delay;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            tmo_d   = 1'b0;
`ifdef PW_SEQ_TIMEOUT_EN
            to_d    = I_timeout;
            tcnt_d  = I_timeout - TO_ONE;
`endif
          end
        end
        ST_ARMED: begin
          // A match in the expiry cycle takes precedence over the timeout.
          if (I_match) begin
            if (dly_q == '0) begin
              state_d = ST_CAPTURE;
            end else begin
              state_d = ST_DELAY;
              dcnt_d  = dly_q - DLY_ONE;
            end
          end
`ifdef PW_SEQ_TIMEOUT_EN
          else if (to_q != '0) begin
            if (tcnt_q == '0) begin
              state_d = ST_DONE;
              tmo_d   = 1'b1;
            end else begin
              tcnt_d = tcnt_q - TO_ONE;
            end
          end
`endif
        end
        ST_DELAY: begin
          if (dcnt_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            dcnt_d = dcnt_q - DLY_ONE;
          end
        end
        ST_CAPTURE: begin
          if (I_fe_wr) begin
            cnt_d = cnt_inc;
          end
          if (I_fifo_full) begin
            ovf_d   = 1'b1;
            state_d = ST_DONE;
          end else if (I_fe_wr && (len_q != '0) && (cnt_inc == len_q)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!I_arm) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      dly_q   <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dly_q   <= dly_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

`ifdef PW_SEQ_TIMEOUT_EN
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      to_q   <= '0;
      tcnt_q <= '0;
    end else begin
      to_q   <= to_d;
      tcnt_q <= tcnt_d;
    end
  end
  assign O_timeout = tmo_q;
`else
  assign O_timeout = 1'b0;
`endif

  assign O_armed          = (state_q == ST_ARMED);
  assign O_capture_enable = (state_q == ST_CAPTURE);
  assign O_done           = done_q;
  assign O_overflow       = ovf_q;
  assign O_state          = state_q;
  assign O_count          = cnt_q;

endmodule
